// File: rtl/card_display_ctrl.sv
// Card slot scheduler for the four-card 24-game screen: maps each pixel to a slot,
// double-buffers card values with a frame-start commit, and blinks the selected card.
module card_display_ctrl #(
   parameter int X0           = 40,
   parameter int SLOT_PITCH   = 150,
   parameter int Y0           = 170,
   parameter int DIGIT_W      = 80,
   parameter int DIGIT_H      = 140,
   parameter int BLINK_FRAMES = 30
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] sx,
   input  logic [9:0] sy,
   input  logic       frame_start,
   input  logic       wr_valid,
   output logic       wr_ready,
   input  logic [1:0] wr_slot,
   input  logic [3:0] wr_value,
   input  logic       sel_en,
   input  logic [1:0] sel_slot,
   output logic [9:0] sx_offset,
   output logic [9:0] sy_offset,
   output logic [3:0] number,
   output logic       in_digit,
   output logic       blink_on
);

   localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);
   localparam logic [9:0] Y_TOP = 10'(Y0);
   localparam logic [9:0] Y_END = 10'(Y0 + DIGIT_H);

   typedef enum logic [1:0] {
      IDLE,
      DIRTY,
      COMMIT
   } state_t;

   state_t           state;
   state_t           state_next;
   logic             write_accept;
   logic [3:0]       shadow [4];
   logic [3:0]       active [4];
   logic [CNT_W-1:0] blink_cnt;

   logic             slot_hit;
   logic [1:0]       hit_slot;
   logic [9:0]       hit_edge;
   logic             y_hit;
   logic [9:0]       sx_offset_next;
   logic [9:0]       sy_offset_next;
   logic [3:0]       number_next;
   logic             in_digit_next;

   // Writes are refused only while the one-cycle copy into active is happening.
   assign wr_ready     = (state != COMMIT);
   assign write_accept = wr_valid && wr_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (frame_start && write_accept) begin
               state_next = COMMIT;
            end else if (write_accept) begin
               state_next = DIRTY;
            end
         end
         DIRTY: begin
            if (frame_start) begin
               state_next = COMMIT;
            end
         end
         COMMIT:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            shadow[i] <= 4'hF;
         end
      end else if (write_accept) begin
         shadow[wr_slot] <= wr_value;
      end
   end

   // The whole hand moves to active at once so a frame never shows a mix.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            active[i] <= 4'hF;
         end
      end else if (state == COMMIT) begin
         for (int i = 0; i < 4; i++) begin
            active[i] <= shadow[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         blink_cnt <= '0;
         blink_on  <= 1'b1;
      end else if (frame_start) begin
         if (blink_cnt == CNT_LAST) begin
            blink_cnt <= '0;
            blink_on  <= ~blink_on;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      slot_hit = 1'b0;
      hit_slot = 2'd0;
      hit_edge = 10'd0;
      for (int k = 0; k < 4; k++) begin
         if (!slot_hit && (sx >= 10'(X0 + k * SLOT_PITCH)) &&
             (sx < 10'(X0 + k * SLOT_PITCH + DIGIT_W))) begin
            slot_hit = 1'b1;
            hit_slot = 2'(k);
            hit_edge = 10'(X0 + k * SLOT_PITCH);
         end
      end
   end

   assign y_hit = (sy >= Y_TOP) && (sy < Y_END);

   // A selected card disappears during the off half of the blink period.
   always_comb begin
      sx_offset_next = 10'd0;
      sy_offset_next = 10'd0;
      number_next    = 4'hF;
      in_digit_next  = 1'b0;
      if (slot_hit && y_hit) begin
         sx_offset_next = sx - hit_edge;
         sy_offset_next = sy - Y_TOP;
         number_next    = active[hit_slot];
         in_digit_next  = (active[hit_slot] <= 4'd9) &&
                          !(sel_en && (sel_slot == hit_slot) && !blink_on);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sx_offset <= 10'd0;
         sy_offset <= 10'd0;
         number    <= 4'hF;
         in_digit  <= 1'b0;
      end else begin
         sx_offset <= sx_offset_next;
         sy_offset <= sy_offset_next;
         number    <= number_next;
         in_digit  <= in_digit_next;
      end
   end

endmodule

// File: tb/tb_card_display_ctrl.sv
// Directed self-checking bench for card_display_ctrl: reset, deferred commit,
// slot boundaries, write-with-frame-start, blinking selection and mid-run reset.
module tb_card_display_ctrl;

   logic       clk;
   logic       rst;
   logic [9:0] sx;
   logic [9:0] sy;
   logic       frame_start;
   logic       wr_valid;
   logic       wr_ready;
   logic [1:0] wr_slot;
   logic [3:0] wr_value;
   logic       sel_en;
   logic [1:0] sel_slot;
   logic [9:0] sx_offset;
   logic [9:0] sy_offset;
   logic [3:0] number;
   logic       in_digit;
   logic       blink_on;

   int checks;
   int failures;

   card_display_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .sx         (sx),
      .sy         (sy),
      .frame_start(frame_start),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .wr_slot    (wr_slot),
      .wr_value   (wr_value),
      .sel_en     (sel_en),
      .sel_slot   (sel_slot),
      .sx_offset  (sx_offset),
      .sy_offset  (sy_offset),
      .number     (number),
      .in_digit   (in_digit),
      .blink_on   (blink_on)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [9:0] px, input logic [9:0] py);
      sx = px;
      sy = py;
      step();
   endtask

   task automatic writeCard(input logic [1:0] slot, input logic [3:0] value);
      wr_valid = 1'b1;
      wr_slot  = slot;
      wr_value = value;
      step();
      wr_valid = 1'b0;
   endtask

   task automatic pulseFrames(input int n);
      for (int i = 0; i < n; i++) begin
         frame_start = 1'b1;
         step();
         frame_start = 1'b0;
         step();
      end
   endtask

   task automatic doReset();
      rst = 1'b1;
      repeat (3) step();
      rst = 1'b0;
   endtask

   initial begin
      checks = 0;
      failures = 0;
      rst = 1'b0;
      sx = 10'd0;
      sy = 10'd0;
      frame_start = 1'b0;
      wr_valid = 1'b0;
      wr_slot = 2'd0;
      wr_value = 4'd0;
      sel_en = 1'b0;
      sel_slot = 2'd0;

      doReset();
      checkOutput("rst_number", 16'(number), 16'hF);
      checkOutput("rst_in_digit", 16'(in_digit), 16'd0);
      checkOutput("rst_wr_ready", 16'(wr_ready), 16'd1);
      checkOutput("rst_blink_on", 16'(blink_on), 16'd1);
      checkOutput("rst_sx_off", 16'(sx_offset), 16'd0);
      checkOutput("rst_sy_off", 16'(sy_offset), 16'd0);

      // Deferred commit: shadow write not visible until frame_start
      writeCard(2'd2, 4'd7);
      applyStimulus(10'd345, 10'd200);
      checkOutput("defer_number", 16'(number), 16'hF);
      checkOutput("defer_in_digit", 16'(in_digit), 16'd0);
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      checkOutput("commit_ready_low", 16'(wr_ready), 16'd0);
      step();
      checkOutput("commit_ready_high", 16'(wr_ready), 16'd1);
      step();
      checkOutput("commit_number", 16'(number), 16'd7);
      checkOutput("commit_sx_off", 16'(sx_offset), 16'd5);
      checkOutput("commit_sy_off", 16'(sy_offset), 16'd30);
      checkOutput("commit_in_digit", 16'(in_digit), 16'd1);

      // Slot 2 box boundaries
      applyStimulus(10'd419, 10'd200);
      checkOutput("right_in_digit", 16'(in_digit), 16'd1);
      checkOutput("right_sx_off", 16'(sx_offset), 16'd79);
      applyStimulus(10'd420, 10'd200);
      checkOutput("past_right_in_digit", 16'(in_digit), 16'd0);
      checkOutput("past_right_number", 16'(number), 16'hF);
      checkOutput("past_right_sx_off", 16'(sx_offset), 16'd0);
      applyStimulus(10'd345, 10'd169);
      checkOutput("above_in_digit", 16'(in_digit), 16'd0);
      applyStimulus(10'd345, 10'd309);
      checkOutput("bottom_in_digit", 16'(in_digit), 16'd1);
      checkOutput("bottom_sy_off", 16'(sy_offset), 16'd139);
      applyStimulus(10'd345, 10'd310);
      checkOutput("below_in_digit", 16'(in_digit), 16'd0);
      checkOutput("below_sy_off", 16'(sy_offset), 16'd0);

      // Write and frame_start together from IDLE
      wr_valid = 1'b1;
      wr_slot = 2'd0;
      wr_value = 4'd4;
      frame_start = 1'b1;
      step();
      wr_valid = 1'b0;
      frame_start = 1'b0;
      checkOutput("simul_ready_low", 16'(wr_ready), 16'd0);
      step();
      checkOutput("simul_ready_high", 16'(wr_ready), 16'd1);
      applyStimulus(10'd40, 10'd170);
      checkOutput("simul_number", 16'(number), 16'd4);
      checkOutput("simul_in_digit", 16'(in_digit), 16'd1);
      checkOutput("simul_sx_off", 16'(sx_offset), 16'd0);

      // Blink: fresh counter, cards 3 and 5, slot 0 selected
      doReset();
      writeCard(2'd0, 4'd3);
      writeCard(2'd1, 4'd5);
      pulseFrames(29);
      checkOutput("blink_29", 16'(blink_on), 16'd1);
      pulseFrames(1);
      checkOutput("blink_30", 16'(blink_on), 16'd0);
      applyStimulus(10'd50, 10'd200);
      checkOutput("blink_nosel_in_digit", 16'(in_digit), 16'd1);
      sel_en = 1'b1;
      sel_slot = 2'd0;
      applyStimulus(10'd50, 10'd200);
      checkOutput("blink_sel_number", 16'(number), 16'd3);
      checkOutput("blink_sel_in_digit", 16'(in_digit), 16'd0);
      applyStimulus(10'd200, 10'd200);
      checkOutput("blink_other_number", 16'(number), 16'd5);
      checkOutput("blink_other_in_digit", 16'(in_digit), 16'd1);
      checkOutput("blink_other_sx_off", 16'(sx_offset), 16'd10);
      pulseFrames(30);
      checkOutput("blink_60", 16'(blink_on), 16'd1);
      applyStimulus(10'd50, 10'd200);
      checkOutput("blink_back_in_digit", 16'(in_digit), 16'd1);
      sel_en = 1'b0;

      // Reset while DIRTY drops the pending write
      writeCard(2'd1, 4'd9);
      rst = 1'b1;
      step();
      rst = 1'b0;
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      checkOutput("post_rst_ready", 16'(wr_ready), 16'd1);
      step();
      step();
      applyStimulus(10'd200, 10'd200);
      checkOutput("post_rst_number", 16'(number), 16'hF);
      checkOutput("post_rst_in_digit", 16'(in_digit), 16'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
